// File: rtl/ccd_vline_sequencer.sv
// Frame-level line sequencer in front of the CCD vertical-drive controller.
// Define VSEQ_FLUSH_EN to add the flush_lines port and a dummy-shift phase before the image lines.
module ccd_vline_sequencer #(
  parameter int LINE_W        = 12,
  parameter int WDOG_W        = 16,
  parameter int WDOG_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LINE_W-1:0] num_lines,
`ifdef VSEQ_FLUSH_EN
  input  logic [LINE_W-1:0] flush_lines,
`endif
  input  logic [2:0]        vdrv_state,
  output logic              vdrv_trig,
  output logic              hread_start,
  input  logic              hread_done,
  output logic              busy,
  output logic [LINE_W-1:0] line_idx,
  output logic              frame_done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, FLUSH_TRIG, TRIG, WAIT_BUSY, WAIT_DONE, SETTLE, HREAD, DONE, ABORT_WAIT
  } state_t;

  localparam logic [WDOG_W-1:0] WDOG_LAST   = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WDOG_W-1:0] SETTLE_LAST = WDOG_W'(SETTLE_CYCLES - 1);

  state_t            state;
  logic [LINE_W-1:0] num_lat;
  logic [LINE_W-1:0] flush_cnt;
  logic [LINE_W-1:0] flush_dec;
  logic [LINE_W-1:0] start_flush;
  logic [LINE_W-1:0] line_inc;
  logic [WDOG_W-1:0] tmr;
  logic              wdog_hit;

`ifdef VSEQ_FLUSH_EN
  assign start_flush = flush_lines;
`else
  // Without the flush phase the count is tied off, so FLUSH_TRIG can never be entered.
  assign flush_cnt   = '0;
  assign start_flush = '0;
`endif

  assign flush_dec = flush_cnt - LINE_W'(1);
  assign line_inc  = line_idx + LINE_W'(1);
  assign wdog_hit  = (tmr == WDOG_LAST) &&
                     (state == WAIT_BUSY || state == WAIT_DONE || state == HREAD);

  // tmr is the watchdog in the wait states and the settle counter in SETTLE; every
  // state change clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vdrv_trig   <= 1'b0;
      hread_start <= 1'b0;
      busy        <= 1'b0;
      line_idx    <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      num_lat     <= '0;
      tmr         <= '0;
`ifdef VSEQ_FLUSH_EN
      flush_cnt   <= '0;
`endif
    end else begin
      // NOTE: pulse outputs default low here; a later non-blocking write in the same pass wins.
      vdrv_trig   <= 1'b0;
      hread_start <= 1'b0;
      frame_done  <= 1'b0;

      if (state == IDLE) begin
        if (start && !abort) begin
          num_lat  <= num_lines;
          line_idx <= '0;
          err      <= 1'b0;
          busy     <= 1'b1;
          tmr      <= '0;
`ifdef VSEQ_FLUSH_EN
          flush_cnt <= flush_lines;
`endif
          if (start_flush != '0)      state <= FLUSH_TRIG;
          else if (num_lines == '0)   state <= DONE;
          else                        state <= TRIG;
        end
      end else if (abort) begin
        state <= ABORT_WAIT;
        tmr   <= '0;
      end else if (wdog_hit) begin
        err   <= 1'b1;
        state <= ABORT_WAIT;
        tmr   <= '0;
      end else begin
        case (state)
          FLUSH_TRIG, TRIG: begin
            vdrv_trig <= 1'b1;
            state     <= WAIT_BUSY;
            tmr       <= '0;
          end
          WAIT_BUSY: begin
            // State 0 also covers the controller's initial deadtime; only nonzero proves the shift began.
            if (vdrv_state != 3'd0) begin
              state <= WAIT_DONE;
              tmr   <= '0;
            end else begin
              tmr <= tmr + WDOG_W'(1);
            end
          end
          WAIT_DONE: begin
            if (vdrv_state == 3'd0) begin
              tmr <= '0;
              if (flush_cnt != '0) begin
`ifdef VSEQ_FLUSH_EN
                flush_cnt <= flush_dec;
`endif
                if (flush_dec != '0)      state <= FLUSH_TRIG;
                else if (num_lat == '0)   state <= DONE;
                else                      state <= TRIG;
              end else if (SETTLE_CYCLES == 0) begin
                state       <= HREAD;
                hread_start <= 1'b1;
              end else begin
                state <= SETTLE;
              end
            end else begin
              tmr <= tmr + WDOG_W'(1);
            end
          end
          SETTLE: begin
            if (tmr == SETTLE_LAST) begin
              state       <= HREAD;
              hread_start <= 1'b1;
              tmr         <= '0;
            end else begin
              tmr <= tmr + WDOG_W'(1);
            end
          end
          HREAD: begin
            if (hread_done) begin
              line_idx <= line_inc;
              tmr      <= '0;
              state    <= (line_inc == num_lat) ? DONE : TRIG;
            end else begin
              tmr <= tmr + WDOG_W'(1);
            end
          end
          DONE: begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
          ABORT_WAIT: begin
            if (vdrv_state == 3'd0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
            tmr   <= '0;
          end
        endcase
      end
    end
  end

endmodule
